// File: rtl/sys_stream_upsize_pkg.sv
// Shared typedefs and stream helpers for the byte-to-word upsizer.
// SYS_UPSIZE_BIG_ENDIAN_EN selects MSB-first lane placement and MSB-aligned keep masks.
package sys_pkg_type;

    typedef logic [7:0]  u8;
    typedef logic [31:0] u32;

endpackage

package sys_pkg_stream;

    localparam int SYS_UPSIZE_RATIO_MAX = 8;

    // Keep mask for a word whose last written lane index is cnt.
    function automatic logic [SYS_UPSIZE_RATIO_MAX-1:0] keep_mask(input int cnt, input int ratio);
        logic [SYS_UPSIZE_RATIO_MAX-1:0] m;
`ifdef SYS_UPSIZE_BIG_ENDIAN_EN
        m = SYS_UPSIZE_RATIO_MAX'(((1 << (cnt + 1)) - 1) << (ratio - 1 - cnt));
`else
        m = SYS_UPSIZE_RATIO_MAX'((1 << (cnt + 1)) - 1);
        if (cnt >= ratio) m = '0;
`endif
        return m;
    endfunction

    // Bit offset of lane idx inside the wide word.
    function automatic int lane_lsb(input int idx, input int ratio, input int in_w);
        if (idx >= ratio) return 0;
`ifdef SYS_UPSIZE_BIG_ENDIAN_EN
        return (ratio - 1 - idx) * in_w;
`else
        return idx * in_w;
`endif
    endfunction

endpackage

// File: rtl/sys_upsize_acc.sv
// Lane counter and accumulator; presents the merged word combinationally so the
// top can capture it on the completing beat.
module sys_upsize_acc
    import sys_pkg_stream::*;
#(
    parameter  int IN_W  = 8,
    parameter  int RATIO = 4,
    localparam int OUT_W = IN_W * RATIO,
    localparam int CW    = $clog2(RATIO)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_beat,
    input  logic [IN_W-1:0]  i_data,
    input  logic             i_last,
    output logic             o_done,
    output logic [OUT_W-1:0] o_word,
    output logic [RATIO-1:0] o_keep
);

    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

    logic [CW-1:0]    r_cnt;
    logic [OUT_W-1:0] r_acc;

    assign o_done = i_beat && (i_last || (r_cnt == LAST_LANE));
    assign o_keep = RATIO'(keep_mask(int'(r_cnt), RATIO));

    // Current beat lands in lane r_cnt; lanes beyond it are always zero in the output.
    for (genvar g = 0; g < RATIO; g++) begin : g_lane
        localparam int LSB = lane_lsb(g, RATIO, IN_W);
        assign o_word[LSB +: IN_W] = (CW'(g) == r_cnt) ? i_data :
                                     (CW'(g) <  r_cnt) ? r_acc[LSB +: IN_W] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (o_done) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (i_beat) begin
            r_cnt <= r_cnt + 1'b1;
            r_acc <= o_word;
        end
    end

endmodule

// File: rtl/sys_stream_upsize.sv
// Valid/ready width upsizer: packs RATIO narrow beats into one wide word, flushing on s_last.
// SYS_UPSIZE_BIG_ENDIAN_EN places the first beat in the most-significant lane.
module sys_stream_upsize
    import sys_pkg_stream::*;
#(
    parameter  int IN_W  = 8,
    parameter  int RATIO = 4,
    localparam int OUT_W = IN_W * RATIO
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IN_W-1:0]  s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic [RATIO-1:0] m_keep,
    output logic             m_last
);

    if (RATIO < 2 || RATIO > SYS_UPSIZE_RATIO_MAX) begin : g_ratio_bad
        $error("sys_stream_upsize: RATIO=%0d outside 2..%0d", RATIO, SYS_UPSIZE_RATIO_MAX);
    end

    logic             r_m_valid;
    logic [OUT_W-1:0] r_m_data;
    logic [RATIO-1:0] r_m_keep;
    logic             r_m_last;

    logic             w_beat;
    logic             w_done;
    logic [OUT_W-1:0] w_word;
    logic [RATIO-1:0] w_keep;

    // A free or draining output slot admits a beat, so a completing beat can refill it back-to-back.
    assign s_ready = !r_m_valid || m_ready;
    assign w_beat  = s_valid && s_ready;

    sys_upsize_acc #(
        .IN_W  (IN_W),
        .RATIO (RATIO)
    ) u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_beat (w_beat),
        .i_data (s_data),
        .i_last (s_last),
        .o_done (w_done),
        .o_word (w_word),
        .o_keep (w_keep)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_keep  <= '0;
            r_m_last  <= 1'b0;
        end else if (w_done) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_word;
            r_m_keep  <= w_keep;
            r_m_last  <= s_last;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_keep  = r_m_keep;
    assign m_last  = r_m_last;

endmodule

// File: tb/tb_sys_stream_upsize.sv
// Self-checking bench for sys_stream_upsize: table vectors plus scoreboarded random traffic.
module tb_sys_stream_upsize;
    import sys_pkg_type::*;

    localparam int RATIO = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid, s_ready, s_last;
    u8          s_data;
    logic       m_valid, m_ready, m_last;
    u32         m_data;
    logic [3:0] m_keep;

    always #5 clk = ~clk;

    sys_stream_upsize #(.IN_W(8), .RATIO(RATIO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_last  (m_last)
    );

    typedef struct {
        u8          d;
        logic       l;
        logic       chk;
        u32         w;
        logic [3:0] k;
        logic       wl;
    } vec_t;

    typedef struct {
        u32         w;
        logic [3:0] k;
        logic       l;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[16];
    vec_t none;
    int   checks   = 0;
    int   failures = 0;
    int   stalls   = 0;
    bit   mon_on   = 1'b0;
    bit   t3_done  = 1'b0;
    bit   t6_stop  = 1'b0;
    u32   md;
    int   mc;

    function automatic u32 ew(input u32 le, input u32 be);
`ifdef SYS_UPSIZE_BIG_ENDIAN_EN
        return be;
`else
        return le;
`endif
    endfunction

    function automatic logic [3:0] ek(input logic [3:0] le, input logic [3:0] be);
`ifdef SYS_UPSIZE_BIG_ENDIAN_EN
        return be;
`else
        return le;
`endif
    endfunction

    function automatic vec_t mk(input u8 d, input logic l, input logic c, input u32 w,
                                input logic [3:0] k, input logic wl);
        vec_t v;
        v.d = d; v.l = l; v.chk = c; v.w = w; v.k = k; v.wl = wl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference packing model; table mode pushes the table's expectation instead.
    task automatic model_beat(input u8 d, input logic l, input bit use_tbl, input vec_t v);
        exp_t e;
        int   lsb;
`ifdef SYS_UPSIZE_BIG_ENDIAN_EN
        lsb = (RATIO - 1 - mc) * 8;
`else
        lsb = mc * 8;
`endif
        md = md | (u32'(d) << lsb);
        if (use_tbl) begin
            if (v.chk) begin
                e.w = v.w; e.k = v.k; e.l = v.wl;
                sb.push_back(e);
            end
        end else if (mc == RATIO - 1 || l) begin
            e.w = md;
`ifdef SYS_UPSIZE_BIG_ENDIAN_EN
            e.k = 4'(((1 << (mc + 1)) - 1) << (RATIO - 1 - mc));
`else
            e.k = 4'((1 << (mc + 1)) - 1);
`endif
            e.l = l;
            sb.push_back(e);
        end
        if (mc == RATIO - 1 || l) begin
            md = '0;
            mc = 0;
        end else begin
            mc++;
        end
    endtask

    task automatic send(input u8 d, input logic l, input bit use_tbl, input vec_t v);
        bit acc;
        int n;
        n = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        do begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            n++;
        end while (!acc && n < 500);
        #1;
        if (!acc) chk("send_timeout", 64'(n), 64'(0));
        else begin
            stalls += n - 1;
            model_beat(d, l, use_tbl, v);
        end
    endtask

    task automatic run_tbl(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send(tbl[i].d, tbl[i].l, 1'b1, tbl[i]);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, 64'(sb.size()), 64'(0));
        sb.delete();
    endtask

    // Output monitor: a pending expected word must be on the bus, and every handshake pops one.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("m_valid_vs_pending", 64'(m_valid), 64'(sb.size() != 0));
            if (m_valid && m_ready && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("m_data", 64'(m_data), 64'(e.w));
                chk("m_keep", 64'(m_keep), 64'(e.k));
                chk("m_last", 64'(m_last), 64'(e.l));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        u32 first;
        int n, len;

        none = mk(8'h00, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 8; i++) tbl[i] = mk(u8'(8'h11 * (i + 1)), 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        tbl[3]  = mk(8'h44, 1'b0, 1'b1, ew(32'h44332211, 32'h11223344), 4'hF, 1'b0);
        tbl[7]  = mk(8'h88, 1'b0, 1'b1, ew(32'h88776655, 32'h55667788), 4'hF, 1'b0);
        tbl[8]  = mk(8'hAA, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        tbl[9]  = mk(8'hBB, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        tbl[10] = mk(8'hCC, 1'b1, 1'b1, ew(32'h00CCBBAA, 32'hAABBCC00), ek(4'h7, 4'hE), 1'b1);
        tbl[11] = mk(8'h5A, 1'b1, 1'b1, ew(32'h0000005A, 32'h5A000000), ek(4'h1, 4'h8), 1'b1);
        tbl[12] = mk(8'h01, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        tbl[13] = mk(8'h02, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        tbl[14] = mk(8'h03, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        tbl[15] = mk(8'h04, 1'b0, 1'b1, ew(32'h04030201, 32'h01020304), 4'hF, 1'b0);

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_m_data",  64'(m_data),  64'(0));
        chk("rst_m_keep",  64'(m_keep),  64'(0));
        chk("rst_m_last",  64'(m_last),  64'(0));
        chk("rst_s_ready", 64'(s_ready), 64'(1));
        rst_n = 1'b1; m_ready = 1'b1; md = '0; mc = 0;
        mon_on = 1'b1;

        // T1: two full words at one beat per cycle
        stalls = 0;
        run_tbl(0, 7);
        chk("t1_stalls", 64'(stalls), 64'(0));
        // T2 partial packet, T4 single-lane packet
        run_tbl(8, 10);
        run_tbl(11, 11);
        drain("t124_drain");

        // T3: output back-pressure during a continuous stream
        m_ready = 1'b0;
        first = ew(32'hA3A2A1A0, 32'hA0A1A2A3);
        fork
            begin
                for (int i = 0; i < 8; i++) send(u8'(8'hA0 + i), 1'b0, 1'b0, none);
                s_valid = 1'b0;
                t3_done = 1'b1;
            end
        join_none
        repeat (5) @(posedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("t3_s_ready_low", 64'(s_ready), 64'(0));
            chk("t3_m_data_hold", 64'(m_data), 64'(first));
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        n = 0;
        while (!t3_done && n < 100) begin
            @(posedge clk);
            n++;
        end
        #2;
        chk("t3_stream_done", 64'(t3_done), 64'(1));
        drain("t3_drain");

        // T5: reset in the middle of a word discards it
        send(8'hE1, 1'b0, 1'b0, none);
        send(8'hE2, 1'b0, 1'b0, none);
        s_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1; md = '0; mc = 0;
        chk("t5_m_valid", 64'(m_valid), 64'(0));
        chk("t5_m_data",  64'(m_data),  64'(0));
        chk("t5_m_keep",  64'(m_keep),  64'(0));
        run_tbl(12, 15);
        drain("t5_drain");

        // T6: random back-pressure with mixed packet lengths and bursts of single-beat packets
        fork
            begin
                while (!t6_stop) begin
                    @(posedge clk);
                    #1;
                    m_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int p = 0; p < 60; p++) begin
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) send(u8'($urandom), (b == len - 1), 1'b0, none);
        end
        for (int b = 0; b < 20; b++) send(u8'($urandom), 1'b1, 1'b0, none);
        s_valid = 1'b0; s_last = 1'b0;
        t6_stop = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        m_ready = 1'b1;
        drain("t6_drain");

        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
